register_pair_bank: RTL

- Bank of PAIRS register pairs for the CPU datapath (address pointers, stack pointer, general pairs).
- Each pair is accessed as a high half, a low half, or a full double-width word over the shared bus.
- Adds per-pair increment/decrement with carry across the halves, so pointer post-increment needs no ALU pass.
- Output is registered; bus drive is signalled by an explicit enable instead of an internal tri-state.

---
 rtl/register_pair_bank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/register_pair_bank.sv
`default_nettype none
// ============================================================================
//  Module      : register_pair_bank
//  Description : Bank of register pairs, each readable/writable as a high
//                half, low half or full double-width word. A per-pair
//                increment/decrement step carries across the halves, and all
//                outputs are registered with an explicit bus drive enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_pair_bank #(
    parameter int                    HALF_W    = 8,
    parameter int                    PAIRS     = 4,
    parameter int                    SEL_W     = 2,
    parameter logic [2*HALF_W-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*HALF_W-1:0]   bus_in,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  cs_h_in,
    input  logic                  cs_l_in,
    input  logic                  cs_16_in,
    input  logic [SEL_W-1:0]      sel_out,
    input  logic                  cs_h_out,
    input  logic                  cs_l_out,
    input  logic                  cs_16_out,
    input  logic [SEL_W-1:0]      sel_step,
    input  logic                  inc,
    input  logic                  dec,
    output logic [2*HALF_W-1:0]   bus_out,
    output logic                  bus_oe,
    output logic                  step_wrap,
    output logic                  step_zero
);

    localparam int               c_BUS_W = 2 * HALF_W;
    localparam logic [SEL_W:0]   c_PAIRS = (SEL_W + 1)'(PAIRS);
    localparam logic [c_BUS_W-1:0] c_ONE = {{(c_BUS_W - 1){1'b0}}, 1'b1};

    // Pair storage and its next-state image
    logic [c_BUS_W-1:0] r_pair_q [PAIRS];
    logic [c_BUS_W-1:0] w_pair_d [PAIRS];

    // Selected operands and decoded controls
    logic [c_BUS_W-1:0] w_rd_pair;
    logic [c_BUS_W-1:0] w_rd_data;
    logic [c_BUS_W-1:0] w_step_cur;
    logic [c_BUS_W-1:0] w_step_res;
    logic               w_step_act;
    logic               w_step_wrap;
    logic               w_rd_any;

    // Selects beyond the populated pairs never match a pair in the muxes
    // below, so reads of them return zero and steps of them are dropped.
    assign w_step_act  = (inc ^ dec) && ({1'b0, sel_step} < c_PAIRS);
    assign w_step_res  = inc ? (w_step_cur + c_ONE) : (w_step_cur - c_ONE);
    assign w_step_wrap = inc ? (&w_step_cur) : (w_step_cur == '0);
    assign w_rd_any    = cs_h_out | cs_l_out | cs_16_out;

    // Select the pairs addressed by the read and step ports
    always_comb begin
        w_rd_pair  = '0;
        w_step_cur = '0;
        for (int p = 0; p < PAIRS; p++) begin
            if (sel_out == SEL_W'(p)) begin
                w_rd_pair = r_pair_q[p];
            end
            if (sel_step == SEL_W'(p)) begin
                w_step_cur = r_pair_q[p];
            end
        end
    end

    // Shape read data by strobe priority: high half, low half, full pair
    always_comb begin
        w_rd_data = '0;
        if (cs_h_out) begin
            w_rd_data = {{HALF_W{1'b0}}, w_rd_pair[c_BUS_W-1:HALF_W]};
        end else if (cs_l_out) begin
            w_rd_data = {{HALF_W{1'b0}}, w_rd_pair[HALF_W-1:0]};
        end else if (cs_16_out) begin
            w_rd_data = w_rd_pair;
        end
    end

    // Next pair values: the step applies first, then a write overlays the
    // halves it targets, so an unwritten half keeps the stepped value.
    always_comb begin
        for (int p = 0; p < PAIRS; p++) begin
            w_pair_d[p] = r_pair_q[p];
            if (w_step_act && (sel_step == SEL_W'(p))) begin
                w_pair_d[p] = w_step_res;
            end
            if (sel_in == SEL_W'(p)) begin
                if (cs_h_in) begin
                    w_pair_d[p][c_BUS_W-1:HALF_W] = bus_in[HALF_W-1:0];
                end else if (cs_l_in) begin
                    w_pair_d[p][HALF_W-1:0] = bus_in[HALF_W-1:0];
                end else if (cs_16_in) begin
                    w_pair_d[p] = bus_in;
                end
            end
        end
    end

    // Register pairs, read data and step flags; reset overrides all strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PAIRS; p++) begin
                r_pair_q[p] <= RESET_VAL;
            end
            bus_out   <= '0;
            bus_oe    <= 1'b0;
            step_wrap <= 1'b0;
            step_zero <= 1'b0;
        end else begin
            for (int p = 0; p < PAIRS; p++) begin
                r_pair_q[p] <= w_pair_d[p];
            end
            bus_out <= w_rd_data;
            bus_oe  <= w_rd_any;
            if (w_step_act) begin
                step_wrap <= w_step_wrap;
                step_zero <= (w_step_res == '0);
            end
        end
    end

endmodule
`default_nettype wire
